// File: rtl/dual_mem_responder.sv
// dual_mem_responder
//   Shared byte memory serving two cores through one access FSM
//   (IDLE -> BUSY -> DONE). The FSM grants one requesting port per access,
//   round-robin under contention. It spends LATENCY cycles in BUSY, commits
//   the access on the edge that leaves BUSY, and strobes the granted port's
//   ready for the single DONE cycle.
//
// Parameters
//   WIDTH   : data byte width
//   ADDR_W  : address width; memory depth is 2**ADDR_W
//   LATENCY : BUSY cycles per access (1..15)
//
// Ports
//   clk                     : clock, rising-edge active
//   reset                   : asynchronous, active-high reset
//   memread0 / memread1     : read request per core
//   memwrite0 / memwrite1   : write request per core (wins over read)
//   adr0 / adr1             : byte address per core
//   writedata0 / writedata1 : write byte per core
//   memdata0 / memdata1     : last read byte returned to each core
//   ready0 / ready1         : one-cycle completion strobe per core
module dual_mem_responder #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned LATENCY = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              memread0,
  input  logic              memread1,
  input  logic              memwrite0,
  input  logic              memwrite1,
  input  logic [ADDR_W-1:0] adr0,
  input  logic [ADDR_W-1:0] adr1,
  input  logic [WIDTH-1:0]  writedata0,
  input  logic [WIDTH-1:0]  writedata1,
  output logic [WIDTH-1:0]  memdata0,
  output logic [WIDTH-1:0]  memdata1,
  output logic              ready0,
  output logic              ready1
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_e;

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              gnt_q, gnt_d;     // port owning the current access
  logic              last_q, last_d;   // port granted most recently
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] adr_q, adr_d;
  logic [WIDTH-1:0]  wdata_q, wdata_d;
  logic [WIDTH-1:0]  memdata0_q, memdata0_d;
  logic [WIDTH-1:0]  memdata1_q, memdata1_d;

  // Contents survive reset; the declaration initialiser gives the
  // power-up zero state.
  logic [WIDTH-1:0]  mem_q [DEPTH] = '{default: '0};

  logic              req0, req1;
  logic              pick;
  logic              commit;

  always_comb begin
    req0       = memread0 | memwrite0;
    req1       = memread1 | memwrite1;

    state_d    = state_q;
    cnt_d      = cnt_q;
    gnt_d      = gnt_q;
    last_d     = last_q;
    wr_d       = wr_q;
    adr_d      = adr_q;
    wdata_d    = wdata_q;
    memdata0_d = memdata0_q;
    memdata1_d = memdata1_q;
    pick       = 1'b0;
    commit     = 1'b0;

    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          // Tie goes to the port not granted last; a lone requester wins.
          pick    = (req0 && req1) ? ~last_q : req1;
          gnt_d   = pick;
          last_d  = pick;
          wr_d    = pick ? memwrite1 : memwrite0;
          adr_d   = pick ? adr1 : adr0;
          wdata_d = pick ? writedata1 : writedata0;
          cnt_d   = 4'(LATENCY);
          state_d = BUSY;
        end
      end

      BUSY: begin
        cnt_d = cnt_q - 4'd1;
        // The counter reaches 0 on this edge: commit and move to DONE.
        if (cnt_q == 4'd1) begin
          commit  = 1'b1;
          state_d = DONE;
          if (!wr_q) begin
            if (gnt_q) memdata1_d = mem_q[adr_q];
            else       memdata0_d = mem_q[adr_q];
          end
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      gnt_q      <= 1'b0;
      last_q     <= 1'b1;
      wr_q       <= 1'b0;
      adr_q      <= '0;
      wdata_q    <= '0;
      memdata0_q <= '0;
      memdata1_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      gnt_q      <= gnt_d;
      last_q     <= last_d;
      wr_q       <= wr_d;
      adr_q      <= adr_d;
      wdata_q    <= wdata_d;
      memdata0_q <= memdata0_d;
      memdata1_q <= memdata1_d;
    end
  end

  // Reset forces state_q to IDLE asynchronously, so an access aborted in
  // BUSY never reaches the commit edge; the reset term only guards the
  // edge on which reset is sampled.
  always_ff @(posedge clk) begin
    if (commit && wr_q && !reset) begin
      mem_q[adr_q] <= wdata_q;
    end
  end

  assign memdata0 = memdata0_q;
  assign memdata1 = memdata1_q;
  assign ready0   = (state_q == DONE) && !gnt_q;
  assign ready1   = (state_q == DONE) &&  gnt_q;

endmodule

// File: tb/tb_dual_mem_responder.sv
module tb_dual_mem_responder;

  localparam int unsigned LAT = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       memread0 = 1'b0, memread1 = 1'b0;
  logic       memwrite0 = 1'b0, memwrite1 = 1'b0;
  logic [7:0] adr0 = '0, adr1 = '0;
  logic [7:0] writedata0 = '0, writedata1 = '0;
  logic [7:0] memdata0, memdata1;
  logic       ready0, ready1;

  dual_mem_responder #(
    .WIDTH  (8),
    .ADDR_W (8),
    .LATENCY(LAT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .memread0  (memread0),
    .memread1  (memread1),
    .memwrite0 (memwrite0),
    .memwrite1 (memwrite1),
    .adr0      (adr0),
    .adr1      (adr1),
    .writedata0(writedata0),
    .writedata1(writedata1),
    .memdata0  (memdata0),
    .memdata1  (memdata1),
    .ready0    (ready0),
    .ready1    (ready1)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Transaction-level reference: each access is scheduled in absolute edge
  // numbers. An access sampled on edge s commits on edge s+LAT, its ready is
  // visible for the following cycle, and the next access can be sampled no
  // earlier than edge s+LAT+2.
  logic [7:0] mmem [256];
  logic [7:0] e_md0 = '0, e_md1 = '0;
  logic       e_rdy0 = 1'b0, e_rdy1 = 1'b0;
  int         cyc = 0, done_cyc = 0, free_cyc = 0;
  bit         pend = 1'b0, last = 1'b1, pport = 1'b0, pwr = 1'b0;
  logic [7:0] padr = '0, pdat = '0;

  initial begin
    bit r0, r1;
    for (int i = 0; i < 256; i++) mmem[i] = '0;
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        pend     = 1'b0;
        e_rdy0   = 1'b0;
        e_rdy1   = 1'b0;
        e_md0    = '0;
        e_md1    = '0;
        last     = 1'b1;
        free_cyc = 0;
      end else begin
        cyc++;
        e_rdy0 = 1'b0;
        e_rdy1 = 1'b0;
        if (pend && cyc == done_cyc) begin
          pend = 1'b0;
          if (pwr)             mmem[padr] = pdat;
          else if (pport == 0) e_md0 = mmem[padr];
          else                 e_md1 = mmem[padr];
          if (pport == 0) e_rdy0 = 1'b1;
          else            e_rdy1 = 1'b1;
        end
        r0 = memread0 | memwrite0;
        r1 = memread1 | memwrite1;
        if (!pend && cyc >= free_cyc && (r0 || r1)) begin
          if (r0 && r1) pport = (last == 1'b1) ? 1'b0 : 1'b1;
          else          pport = r1;
          last     = pport;
          pwr      = pport ? memwrite1 : memwrite0;
          padr     = pport ? adr1 : adr0;
          pdat     = pport ? writedata1 : writedata0;
          pend     = 1'b1;
          done_cyc = cyc + LAT;
          free_cyc = cyc + LAT + 2;
        end
      end
    end
  end

  // Cycle-by-cycle comparison against the reference, away from the edge.
  initial begin
    forever begin
      @(negedge clk);
      check("ready0", ready0, e_rdy0);
      check("ready1", ready1, e_rdy1);
      check("memdata0", memdata0, e_md0);
      check("memdata1", memdata1, e_md1);
      check("ready_exclusive", ready0 & ready1, 0);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic wait_rdy(input int port, output int n);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      n++;
      if ((port == 0) ? ready0 : ready1) return;
    end
    check($sformatf("timeout_port%0d", port), 0, 1);
    n = -1;
  endtask

  task automatic access(input int port, input bit rd, input bit wr,
                        input logic [7:0] a, input logic [7:0] d, output int n);
    @(negedge clk);
    if (port == 0) begin
      memread0 = rd; memwrite0 = wr; adr0 = a; writedata0 = d;
    end else begin
      memread1 = rd; memwrite1 = wr; adr1 = a; writedata1 = d;
    end
    wait_rdy(port, n);
    if (port == 0) begin
      memread0 = 1'b0; memwrite0 = 1'b0;
    end else begin
      memread1 = 1'b0; memwrite1 = 1'b0;
    end
  endtask

  initial begin
    int n, n1;
    int order[$];
    int exp_order[8];
    exp_order = '{0, 1, 0, 1, 0, 1, 0, 1};

    // Reset state
    #1 reset = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_ready0", ready0, 0);
    check("rst_ready1", ready1, 0);
    check("rst_memdata0", memdata0, 0);
    check("rst_memdata1", memdata1, 0);
    reset = 1'b0;

    // Single write then read on port 0
    access(0, 1'b0, 1'b1, 8'h10, 8'h24, n);
    check("wr_latency", n, 3);
    access(0, 1'b1, 1'b0, 8'h10, 8'h00, n);
    check("rd_latency", n, 3);
    check("rd_data", memdata0, 8'h24);

    // Simultaneous reads
    access(0, 1'b0, 1'b1, 8'h01, 8'h55, n);
    access(1, 1'b0, 1'b1, 8'h02, 8'hAA, n);
    @(negedge clk);
    memread0 = 1'b1; adr0 = 8'h01;
    memread1 = 1'b1; adr1 = 8'h02;
    wait_rdy(0, n);
    memread0 = 1'b0;
    check("sim_p0_latency", n, 3);
    check("sim_p0_data", memdata0, 8'h55);
    wait_rdy(1, n1);
    memread1 = 1'b0;
    check("sim_p1_extra_latency", n1, 4);
    check("sim_p1_data", memdata1, 8'hAA);

    // Continuous contention: grants must alternate
    @(negedge clk);
    memread0 = 1'b1; adr0 = 8'h01;
    memread1 = 1'b1; adr1 = 8'h02;
    for (int i = 0; i < 100 && order.size() < 8; i++) begin
      @(negedge clk);
      if (ready0) order.push_back(0);
      if (ready1) order.push_back(1);
    end
    memread0 = 1'b0;
    memread1 = 1'b0;
    check("rr_count", order.size(), 8);
    for (int i = 0; i < order.size() && i < 8; i++)
      check($sformatf("rr_grant%0d", i), order[i], exp_order[i]);

    // Cross-port coherence
    access(1, 1'b0, 1'b1, 8'hFF, 8'h5A, n);
    access(0, 1'b1, 1'b0, 8'hFF, 8'h00, n);
    check("xport_md0", memdata0, 8'h5A);
    check("xport_md1_kept", memdata1, 8'hAA);

    // Reset pulse while a write is in BUSY
    @(negedge clk);
    memwrite0 = 1'b1; adr0 = 8'h20; writedata0 = 8'h77;
    @(negedge clk);
    #2 reset = 1'b1;
    #1 check("rst_async_md0", memdata0, 0);
    @(negedge clk);
    memwrite0 = 1'b0;
    check("rst_mid_md1", memdata1, 0);
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("abort_no_ready", ready0 | ready1, 0);
    end
    access(0, 1'b1, 1'b0, 8'h10, 8'h00, n);
    check("post_rst_keep_mem", memdata0, 8'h24);
    access(0, 1'b1, 1'b0, 8'h20, 8'h00, n);
    check("abort_latency", n, 3);
    check("abort_no_write", memdata0, 8'h00);

    // Read and write together on port 1 is a write
    access(1, 1'b1, 1'b0, 8'h02, 8'h00, n);
    check("combo_pre_md1", memdata1, 8'hAA);
    access(1, 1'b1, 1'b1, 8'h40, 8'h33, n);
    check("combo_md1_unchanged", memdata1, 8'hAA);
    access(1, 1'b1, 1'b0, 8'h40, 8'h00, n);
    check("combo_readback_p1", memdata1, 8'h33);
    access(0, 1'b1, 1'b0, 8'h40, 8'h00, n);
    check("combo_readback_p0", memdata0, 8'h33);

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
